// File: rtl/sparc_ifu_par34_chk_pkg.sv
// Package for the IFU 34-bit parity checker.
// Holds the default widths (taken from the shared defines) and the
// stage-1 capture record.
`include "ifu_par_defs.sv"

package sparc_ifu_par34_chk_pkg;
  localparam int PAR_DW = `IFU_PAR_DW;
  localparam int PAR_AW = `IFU_PAR_AW;
  localparam int PAR_CW = `IFU_PAR_CW;

  // Word captured at the first edge; address kept separately since its
  // width is a module parameter.
  typedef struct packed {
    logic [PAR_DW-1:0] data;
    logic              par;
    logic [1:0]        tid;
  } s1_t;
endpackage

// File: rtl/sparc_ifu_par34_chk_if.sv
// Read-side bus of the parity checker.
//   master : array read port / trap logic (drives rd_*, chk_en, log_clr)
//   slave  : sparc_ifu_par34_chk (drives err_* and log_* results)
interface sparc_ifu_par34_chk_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 4
);
  logic              rd_vld;
  logic [33:0]       rd_data;
  logic              rd_par;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_tid;
  logic              rd_kill;
  logic              chk_en;
  logic              log_clr;
  logic              err_pls;
  logic [1:0]        err_tid;
  logic              log_vld;
  logic [ADDR_W-1:0] log_addr;
  logic [1:0]        log_tid;
  logic              log_multi;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output rd_vld, rd_data, rd_par, rd_addr, rd_tid, rd_kill, chk_en, log_clr,
    input  err_pls, err_tid, log_vld, log_addr, log_tid, log_multi, err_cnt
  );

  modport slave (
    input  rd_vld, rd_data, rd_par, rd_addr, rd_tid, rd_kill, chk_en, log_clr,
    output err_pls, err_tid, log_vld, log_addr, log_tid, log_multi, err_cnt
  );
endinterface

// File: rtl/ifu_par_defs.sv
// Shared default widths for the IFU parity encoder/checker pair.
//   IFU_PAR_DW : protected data word width
//   IFU_PAR_AW : array index width logged on error
//   IFU_PAR_CW : saturating error counter width
`ifndef IFU_PAR_DEFS_SV
`define IFU_PAR_DEFS_SV
`define IFU_PAR_DW 34
`define IFU_PAR_AW 8
`define IFU_PAR_CW 4
`endif

// File: rtl/sparc_ifu_par34.sv
// Odd-ones parity encoder for IFU array words. Shared by the write side
// and the checker so both compute parity identically.
//   din : data word
//   par : 1 when din holds an odd number of ones
import sparc_ifu_par34_chk_pkg::*;

module sparc_ifu_par34 #(
  parameter int DW = PAR_DW
) (
  input  logic [DW-1:0] din,
  output logic          par
);
  assign par = ^din;
endmodule

// File: rtl/sparc_ifu_par34_chk.sv
// Two-stage parity checker for 34-bit IFU array reads.
//   rclk, arst_l : clock, async active-low reset
//   bus (slave)  : read word + kill/enable/clear in; error pulse,
//                  first-error log and saturating counter out
// Stage 1 captures the read word; during the following cycle parity is
// recomputed and compared, and rd_kill/chk_en/log_clr are sampled. The
// result is registered at the second edge (err_pls, log, counter).
import sparc_ifu_par34_chk_pkg::*;

module sparc_ifu_par34_chk #(
  parameter int ADDR_W = PAR_AW,
  parameter int CNT_W  = PAR_CW
) (
  input logic rclk,
  input logic arst_l,
  sparc_ifu_par34_chk_if.slave bus
);
  s1_t               s1;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_vld;
  logic              par_calc;
  logic              syn;
  logic              commit;

  logic              err_pls_q;
  logic [1:0]        err_tid_q;
  logic              log_vld_q;
  logic [ADDR_W-1:0] log_addr_q;
  logic [1:0]        log_tid_q;
  logic              log_multi_q;
  logic [CNT_W-1:0]  err_cnt_q;

  // Stage 1: payload only loads on a valid read; s1_vld tracks every cycle.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s1      <= '0;
      s1_addr <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= bus.rd_vld;
      if (bus.rd_vld) begin
        s1.data <= bus.rd_data;
        s1.par  <= bus.rd_par;
        s1.tid  <= bus.rd_tid;
        s1_addr <= bus.rd_addr;
      end
    end
  end

  sparc_ifu_par34 #(.DW(PAR_DW)) u_enc (
    .din (s1.data),
    .par (par_calc)
  );

  assign syn    = par_calc ^ s1.par;
  assign commit = s1_vld & ~bus.rd_kill & bus.chk_en & syn;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      err_pls_q   <= 1'b0;
      err_tid_q   <= '0;
      log_vld_q   <= 1'b0;
      log_addr_q  <= '0;
      log_tid_q   <= '0;
      log_multi_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pls_q <= commit;
      err_tid_q <= s1.tid;
      // A fresh error takes the log even when a clear arrives on the same edge.
      if (commit && (bus.log_clr || !log_vld_q)) begin
        log_vld_q   <= 1'b1;
        log_addr_q  <= s1_addr;
        log_tid_q   <= s1.tid;
        log_multi_q <= 1'b0;
        err_cnt_q   <= CNT_W'(1);
      end else if (commit) begin
        log_multi_q <= 1'b1;
        if (err_cnt_q != {CNT_W{1'b1}})
          err_cnt_q <= err_cnt_q + CNT_W'(1);
      end else if (bus.log_clr) begin
        log_vld_q   <= 1'b0;
        log_addr_q  <= '0;
        log_tid_q   <= '0;
        log_multi_q <= 1'b0;
        err_cnt_q   <= '0;
      end
    end
  end

  assign bus.err_pls   = err_pls_q;
  assign bus.err_tid   = err_tid_q;
  assign bus.log_vld   = log_vld_q;
  assign bus.log_addr  = log_addr_q;
  assign bus.log_tid   = log_tid_q;
  assign bus.log_multi = log_multi_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_sparc_ifu_par34_chk.sv
// Directed bench for sparc_ifu_par34_chk. Each table row is the input set
// driven for one cycle and the outputs expected just after that edge.
module tb_sparc_ifu_par34_chk;
  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 rclk = ~rclk;

  sparc_ifu_par34_chk_if #(.ADDR_W(8), .CNT_W(4)) bus ();

  sparc_ifu_par34_chk #(.ADDR_W(8), .CNT_W(4)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  typedef struct {
    logic        vld;
    logic [33:0] data;
    logic        par;
    logic [7:0]  addr;
    logic [1:0]  tid;
    logic        kill, en, clr;
    logic        pls;
    logic [1:0]  etid;
    logic        lvld;
    logic [7:0]  laddr;
    logic [1:0]  ltid;
    logic        multi;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic vld, logic [33:0] data, logic par, logic [7:0] addr,
                              logic [1:0] tid, logic kill, logic en, logic clr,
                              logic pls, logic [1:0] etid, logic lvld, logic [7:0] laddr,
                              logic [1:0] ltid, logic multi, logic [3:0] cnt);
    vec_t v;
    v.vld = vld; v.data = data; v.par = par; v.addr = addr; v.tid = tid;
    v.kill = kill; v.en = en; v.clr = clr; v.pls = pls; v.etid = etid;
    v.lvld = lvld; v.laddr = laddr; v.ltid = ltid; v.multi = multi; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [33:0] data, input logic par,
                       input logic [7:0] addr, input logic [1:0] tid,
                       input logic kill, input logic en, input logic clr);
    bus.rd_vld = vld; bus.rd_data = data; bus.rd_par = par; bus.rd_addr = addr;
    bus.rd_tid = tid; bus.rd_kill = kill; bus.chk_en = en; bus.log_clr = clr;
  endtask

  task automatic chk_log(input string tag, input logic lvld, input logic [7:0] laddr,
                         input logic [1:0] ltid, input logic multi, input logic [3:0] cnt);
    chk({tag, ".log_vld"},   bus.log_vld,   lvld);
    chk({tag, ".log_addr"},  bus.log_addr,  laddr);
    chk({tag, ".log_tid"},   bus.log_tid,   ltid);
    chk({tag, ".log_multi"}, bus.log_multi, multi);
    chk({tag, ".err_cnt"},   bus.err_cnt,   cnt);
  endtask

  initial begin
    int npls;
    //             vld data           par addr   tid kil en clr | pls etid lvld laddr  ltid m cnt
    tbl[0]  = mk(1, 34'h0,          0, 8'h00, 0, 0, 1, 0,   0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 34'h1,          0, 8'h2A, 2, 0, 1, 0,   0, 0, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(0, 34'h0,          0, 8'h00, 0, 0, 1, 0,   1, 2, 1, 8'h2A, 2, 0, 1);
    tbl[3]  = mk(0, 34'h0,          0, 8'h00, 0, 0, 1, 1,   0, 0, 0, 8'h00, 0, 0, 0);
    tbl[4]  = mk(1, 34'h1,          0, 8'h01, 1, 0, 1, 0,   0, 0, 0, 8'h00, 0, 0, 0);
    tbl[5]  = mk(1, 34'h3,          1, 8'h02, 3, 0, 1, 0,   1, 1, 1, 8'h01, 1, 0, 1);
    tbl[6]  = mk(1, 34'h0,          1, 8'h03, 0, 0, 1, 0,   1, 3, 1, 8'h01, 1, 1, 2);
    tbl[7]  = mk(0, 34'h0,          0, 8'h00, 0, 0, 1, 0,   1, 0, 1, 8'h01, 1, 1, 3);
    tbl[8]  = mk(1, 34'h3_0000_0001, 1, 8'h09, 0, 0, 1, 0,  0, 0, 1, 8'h01, 1, 1, 3);
    tbl[9]  = mk(1, 34'h2_0000_0000, 0, 8'h07, 1, 0, 1, 0,  0, 0, 1, 8'h01, 1, 1, 3);
    tbl[10] = mk(0, 34'h0,          0, 8'h00, 0, 1, 1, 0,   0, 0, 1, 8'h01, 1, 1, 3);
    tbl[11] = mk(1, 34'h1,          0, 8'h08, 2, 0, 1, 0,   0, 0, 1, 8'h01, 1, 1, 3);
    tbl[12] = mk(0, 34'h0,          0, 8'h00, 0, 0, 0, 0,   0, 0, 1, 8'h01, 1, 1, 3);
    tbl[13] = mk(0, 34'h0,          0, 8'h00, 0, 1, 1, 0,   0, 0, 1, 8'h01, 1, 1, 3);
    tbl[14] = mk(1, 34'h1,          0, 8'h55, 1, 0, 1, 0,   0, 0, 1, 8'h01, 1, 1, 3);
    tbl[15] = mk(0, 34'h0,          0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 8'h55, 1, 0, 1);
    tbl[16] = mk(0, 34'h0,          0, 8'h00, 0, 0, 1, 1,   0, 0, 0, 8'h00, 0, 0, 0);

    drive(0, 34'h0, 0, 8'h00, 0, 0, 1, 0);
    repeat (2) @(posedge rclk);
    #1;
    chk("reset.err_pls", bus.err_pls, 1'b0);
    chk_log("reset", 0, 8'h00, 0, 0, 0);
    arst_l = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].par, tbl[i].addr, tbl[i].tid,
            tbl[i].kill, tbl[i].en, tbl[i].clr);
      @(posedge rclk);
      #1;
      chk($sformatf("row%0d.err_pls", i), bus.err_pls, tbl[i].pls);
      if (tbl[i].pls)
        chk($sformatf("row%0d.err_tid", i), bus.err_tid, tbl[i].etid);
      chk_log($sformatf("row%0d", i), tbl[i].lvld, tbl[i].laddr, tbl[i].ltid,
              tbl[i].multi, tbl[i].cnt);
    end

    // 20 back-to-back bad words: counter saturates at 15, first address kept.
    npls = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) drive(1, 34'h1, 0, 8'h10 + 8'(i), 2'(i), 0, 1, 0);
      else        drive(0, 34'h0, 0, 8'h00, 0, 0, 1, 0);
      @(posedge rclk);
      #1;
      if (bus.err_pls) npls++;
    end
    chk("sat.pulses", 64'(npls), 64'd20);
    chk_log("sat", 1, 8'h10, 0, 1, 4'hF);

    // Async reset with a bad word sitting in stage 1.
    drive(1, 34'h1, 0, 8'h77, 3, 0, 1, 0);
    @(posedge rclk);
    #3;
    arst_l = 1'b0;
    #1;
    chk("arst.err_pls", bus.err_pls, 1'b0);
    chk_log("arst", 0, 8'h00, 0, 0, 0);
    drive(0, 34'h0, 0, 8'h00, 0, 0, 1, 0);
    @(negedge rclk);
    arst_l = 1'b1;
    npls = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge rclk);
      #1;
      if (bus.err_pls) npls++;
    end
    chk("arst.no_stale_pls", 64'(npls), 64'd0);
    chk("arst.err_cnt_after", bus.err_cnt, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sparc_ifu_par34_chk.md
Name: sparc_ifu_par34_chk

Overview:
- Pipelined parity checker for 34-bit IFU array words (e.g., fetch/tag data) read back alongside the stored parity bit.
- Recomputes odd-ones parity, compares it with the stored bit and reports a one-cycle error pulse per bad word.
- Keeps a first-error log (address, thread, multi-error flag) and a saturating error counter for trap/diagnostic logic.
- Sits on the read side of any array whose write side generates parity with sparc_ifu_par34.

Parameters:
- ADDR_W, 8, width of the array index logged on error
- CNT_W, 4, width of the saturating error counter

Ports:
- rclk  in  1  clock
- arst_l  in  1  asynchronous active-low reset
- rd_vld  in  1  read word valid this cycle
- rd_data  in  34  data word read from array
- rd_par  in  1  stored parity bit (1 = odd number of ones written)
- rd_addr  in  ADDR_W  array index of the word
- rd_tid  in  2  thread id of the read
- rd_kill  in  1  cancels the word currently in stage 1 (flush)
- chk_en  in  1  global check enable
- log_clr  in  1  clears log and counter (one-cycle pulse)
- err_pls  out  1  one-cycle parity error pulse
- err_tid  out  2  thread id associated with err_pls
- log_vld  out  1  first-error log holds an entry
- log_addr  out  ADDR_W  address of first logged error
- log_tid  out  2  thread of first logged error
- log_multi  out  1  further error(s) seen while log_vld=1
- err_cnt  out  CNT_W  saturating count of errors since clear

Behaviour:
- Reset (arst_l=0, asynchronous): all stage registers and all outputs go to 0 immediately. Pipeline contents are discarded; a word in flight at reset is never reported.
- Stage 1, edge E0:
  - if rd_vld=1: capture rd_data, rd_par, rd_addr, rd_tid; s1_vld=1
  - else s1_vld=0
- Compare, during the cycle after E0:
  - syn = (^s1_data) XOR s1_par
  - commit = s1_vld & ~rd_kill & chk_en & syn
  - rd_kill is sampled in the cycle after E0, i.e. it applies to the stage-1 word.
- Stage 2, edge E1: err_pls = commit, err_tid = s1_tid. err_pls is high exactly one cycle; latency from rd_vld to err_pls = 2 cycles.
- Back-to-back reads, one per cycle, are fully pipelined. No stall and no backpressure.
- Log update at E1, in priority order:
  1. commit & (log_clr | ~log_vld): log_vld=1, log_addr/log_tid loaded from stage 1, log_multi=0, err_cnt=1. A new error wins over a simultaneous clear.
  2. commit & log_vld & ~log_clr: log fields hold, log_multi=1, err_cnt increments and saturates at 2^CNT_W-1 (no wrap).
  3. log_clr & ~commit: log_vld=0, log_multi=0, err_cnt=0; log_addr/log_tid are reset to 0.
  4. otherwise: hold.
- chk_en=0 suppresses commit only. The pipeline still advances; log and counter hold.
- rd_kill with s1_vld=0 has no effect.
- Parity of all-zero data with rd_par=0 is good. A single-bit flip in data or parity gives syn=1. Double flips are undetected by design.

Decomposition:
- Shared Verilog include (ifu_par_defs) holds the default widths: IFU_PAR_DW=34, IFU_PAR_AW=8, IFU_PAR_CW=4.
- One sub-module: instantiate sparc_ifu_par34 on s1_data for the recomputed parity, so the encoder and checker cannot diverge.
- Log and counter stay in this module; no further split.

Test Plan:
- Reset, then rd_data=34'h0, rd_par=0, rd_vld=1 -> err_pls stays 0, log_vld=0, err_cnt=0.
- rd_data=34'h1, rd_par=0, addr=8'h2A, tid=2 at E0 -> err_pls=1 and err_tid=2 after E1 only. log_vld=1, log_addr=8'h2A, log_tid=2, err_cnt=1, log_multi=0.
- Three consecutive bad words at addrs 1,2,3 -> three err_pls pulses on consecutive cycles. log_addr=1, log_multi=1, err_cnt=3. With CNT_W=4 and 20 bad words, err_cnt=15 (saturates).
- Bad word with rd_kill=1 the next cycle, or with chk_en=0 -> no err_pls; log and err_cnt unchanged.
- log_clr on the same edge as a committing error at addr 8'h55 -> log_vld=1, log_addr=8'h55, log_multi=0, err_cnt=1. log_clr alone -> all log outputs 0.
- Assert arst_l=0 mid-cycle with a bad word in stage 1 -> outputs 0 immediately. After release no err_pls appears for that word.
